// File: rtl/iomem_timer.sv
`default_nettype none
// ============================================================================
// Module      : iomem_timer
// Description : Down-counting timer with prescaler, auto-reload and a level
//               interrupt, mapped into its own 16 MB window of the iomem bus.
// Revision    : 1.0 - initial release
// ============================================================================
module iomem_timer #(
    parameter logic [7:0] ADDR_HI = 8'h04,
    parameter int         PRESC_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iomem_valid,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic        iomem_ready,
    output logic [31:0] iomem_rdata,
    output logic        irq
);
    localparam logic [1:0] c_REG_CTRL   = 2'd0;
    localparam logic [1:0] c_REG_COUNT  = 2'd1;
    localparam logic [1:0] c_REG_RELOAD = 2'd2;
    localparam logic [1:0] c_REG_STATUS = 2'd3;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [3:0]  strb,
                                                input logic [31:0] data);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
        end
        return res;
    endfunction

    logic               en_q, en_d, ar_q, ar_d, ie_q, ie_d, exp_q, exp_d;
    logic               ready_q, ready_d;
    logic [PRESC_W-1:0] presc_q, presc_d, pcnt_q, pcnt_d;
    logic [31:0]        count_q, count_d, reload_q, reload_d, rdata_q, rdata_d;

    logic               sel, wr, tick, expire;
    logic [1:0]         idx;
    logic [31:0]        ctrl_word, ctrl_tick, ctrl_wr, rd_word;
    logic               unused_bits;

    always_comb begin
        sel    = iomem_valid && !ready_q && (iomem_addr[31:24] == ADDR_HI);
        wr     = sel && (iomem_wstrb != 4'd0);
        idx    = iomem_addr[3:2];

        ctrl_word              = '0;
        ctrl_word[0]           = en_q;
        ctrl_word[1]           = ar_q;
        ctrl_word[2]           = ie_q;
        ctrl_word[16 +: PRESC_W] = presc_q;

        case (idx)
            c_REG_CTRL:   rd_word = ctrl_word;
            c_REG_COUNT:  rd_word = count_q;
            c_REG_RELOAD: rd_word = reload_q;
            default:      rd_word = {31'd0, exp_q};
        endcase

        tick   = en_q && (pcnt_q == presc_q);
        expire = tick && (count_q == 32'd0);
        pcnt_d = (!en_q || tick) ? '0 : pcnt_q + PRESC_W'(1);

        count_d   = count_q;
        reload_d  = reload_q;
        exp_d     = exp_q | expire;
        ctrl_tick = ctrl_word;
        if (tick) begin
            if (count_q != 32'd0)  count_d = count_q - 32'd1;
            else if (ar_q)         count_d = reload_q;
            else                   ctrl_tick[0] = 1'b0;
        end

        // Bus writes override the timer's own update of the same register.
        ctrl_wr = (wr && (idx == c_REG_CTRL)) ?
                  merge_bytes(ctrl_tick, iomem_wstrb, iomem_wdata) : ctrl_tick;
        if (wr) begin
            case (idx)
                c_REG_COUNT:  count_d  = merge_bytes(count_q, iomem_wstrb, iomem_wdata);
                c_REG_RELOAD: reload_d = merge_bytes(reload_q, iomem_wstrb, iomem_wdata);
                c_REG_STATUS: if (iomem_wstrb[0] && iomem_wdata[0] && !expire) exp_d = 1'b0;
                default:      ;
            endcase
        end

        en_d    = ctrl_wr[0];
        ar_d    = ctrl_wr[1];
        ie_d    = ctrl_wr[2];
        presc_d = ctrl_wr[16 +: PRESC_W];

        ready_d = sel;
        rdata_d = sel ? rd_word : 32'd0;
    end

    assign unused_bits = ^{iomem_addr[23:4], iomem_addr[1:0], ctrl_wr[15:3]};

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q     <= 1'b0;
            ar_q     <= 1'b0;
            ie_q     <= 1'b0;
            exp_q    <= 1'b0;
            ready_q  <= 1'b0;
            presc_q  <= '0;
            pcnt_q   <= '0;
            count_q  <= 32'd0;
            reload_q <= 32'd0;
            rdata_q  <= 32'd0;
        end else begin
            en_q     <= en_d;
            ar_q     <= ar_d;
            ie_q     <= ie_d;
            exp_q    <= exp_d;
            ready_q  <= ready_d;
            presc_q  <= presc_d;
            pcnt_q   <= pcnt_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            rdata_q  <= rdata_d;
        end
    end

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign irq         = exp_q & ie_q;

endmodule
`default_nettype wire

// File: tb/tb_iomem_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_iomem_timer
// Description : Self-checking bench for iomem_timer: register-level model
//               compared every cycle, plus directed hand-computed checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iomem_timer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        iomem_valid = 1'b0;
    logic [3:0]  iomem_wstrb = 4'd0;
    logic [31:0] iomem_addr = 32'd0;
    logic [31:0] iomem_wdata = 32'd0;
    logic        iomem_ready;
    logic [31:0] iomem_rdata;
    logic        irq;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit chk_en = 1'b0;
    logic irq_prev = 1'b0;
    int rises[$];

    always #5 clk = ~clk;

    iomem_timer #(.ADDR_HI(8'h04), .PRESC_W(16)) dut (
        .clk(clk), .reset(reset), .iomem_valid(iomem_valid),
        .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
        .iomem_wdata(iomem_wdata), .iomem_ready(iomem_ready),
        .iomem_rdata(iomem_rdata), .irq(irq)
    );

    // Register-level view of the peripheral: one word per register.
    typedef struct packed {
        logic        ready;
        logic [31:0] rdata;
        logic [31:0] ctrl;
        logic [31:0] count;
        logic [31:0] reload;
        logic        exp;
        logic [15:0] pcnt;
    } mst_t;

    mst_t m = '0;

    function automatic mst_t step(input mst_t s, input logic rst, input logic v,
                                  input logic [3:0] ws, input logic [31:0] a,
                                  input logic [31:0] wd);
        mst_t n;
        logic sel, tick, expired;
        logic [31:0] regs [4];
        n = s;
        if (rst) return '0;
        sel     = v && !s.ready && (a[31:24] == 8'h04);
        tick    = s.ctrl[0] && (s.pcnt == s.ctrl[31:16]);
        expired = tick && (s.count == 0);
        regs[0] = s.ctrl; regs[1] = s.count; regs[2] = s.reload; regs[3] = {31'd0, s.exp};
        n.pcnt  = (s.ctrl[0] && !tick) ? s.pcnt + 16'd1 : 16'd0;
        if (tick && !expired) n.count = s.count - 1;
        if (expired) begin
            n.exp = 1'b1;
            if (s.ctrl[1]) n.count = s.reload;
            else           n.ctrl[0] = 1'b0;
        end
        n.ready = sel;
        n.rdata = sel ? regs[a[3:2]] : 32'd0;
        if (sel && ws != 4'd0) begin
            if (a[3:2] == 2'd1) n.count = s.count;
            for (int b = 0; b < 4; b++) begin
                if (ws[b]) begin
                    case (a[3:2])
                        2'd0: n.ctrl[8*b +: 8]   = wd[8*b +: 8];
                        2'd1: n.count[8*b +: 8]  = wd[8*b +: 8];
                        2'd2: n.reload[8*b +: 8] = wd[8*b +: 8];
                        default: if (b == 0 && wd[0] && !expired) n.exp = 1'b0;
                    endcase
                end
            end
        end
        n.ctrl = n.ctrl & 32'hFFFF_0007;
        return n;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        m   <= step(m, reset, iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", {31'd0, iomem_ready}, {31'd0, m.ready});
            if (m.ready) check("rdata", iomem_rdata, m.rdata);
            check("irq", {31'd0, irq}, {31'd0, m.exp & m.ctrl[2]});
            if (irq && !irq_prev) rises.push_back(cyc);
        end
        irq_prev <= irq;
    end

    task automatic bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                       output logic [31:0] rd, output bit got, output int at);
        @(posedge clk); #1;
        iomem_valid = 1'b1; iomem_addr = a; iomem_wstrb = s; iomem_wdata = d;
        got = 1'b0; rd = 32'd0; at = -1;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge clk);
            if (iomem_ready) begin got = 1'b1; rd = iomem_rdata; at = cyc; end
        end
        @(posedge clk); #1;
        iomem_valid = 1'b0; iomem_wstrb = 4'd0;
    endtask

    task automatic wr_at(input logic [31:0] a, input logic [31:0] d, output int at);
        logic [31:0] r; bit got;
        bus(a, 4'hF, d, r, got, at);
        check("wr_ack", {31'd0, got}, 32'd1);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        int at;
        wr_at(a, d, at);
    endtask

    task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp, input string name);
        logic [31:0] r; bit got; int at;
        bus(a, 4'h0, 32'd0, r, got, at);
        check({name, "_ack"}, {31'd0, got}, 32'd1);
        check(name, r, exp);
    endtask

    task automatic wait_rises(input int n, input int budget);
        for (int i = 0; i < budget && rises.size() < n; i++) @(negedge clk);
        check("irq_rise_seen", {31'd0, rises.size() >= n}, 32'd1);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        bit got;
        int t_en, at;

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1'b1;

        // Reset state
        rd_chk(32'h0400_0000, 32'd0, "rst_ctrl");
        rd_chk(32'h0400_0004, 32'd0, "rst_count");
        rd_chk(32'h0400_0008, 32'd0, "rst_reload");
        rd_chk(32'h0400_000C, 32'd0, "rst_status");
        check("rst_irq", {31'd0, irq}, 32'd0);

        // Handshake, pre-write rdata, byte lanes, address aliasing
        wr(32'h0400_0008, 32'h1234_5678);
        rd_chk(32'h0400_0008, 32'h1234_5678, "reload_rd");
        bus(32'h0400_0008, 4'b0010, 32'hFFFF_FFFF, r, got, at);
        check("lane_wr_prewrite", r, 32'h1234_5678);
        rd_chk(32'h0400_000A, 32'h1234_FF78, "reload_lane");

        // Periodic: (3+1)*(2+1) = 12 cycles per expiry
        wr(32'h0400_0008, 32'd3);
        wr(32'h0400_0004, 32'd3);
        rises.delete();
        wr_at(32'h0400_0000, 32'h0002_0007, t_en);
        wait_rises(1, 40);
        if (rises.size() >= 1) check("periodic_first", rises[0] - t_en, 32'd12);
        wr(32'h0400_000C, 32'd1);
        wait_rises(2, 40);
        if (rises.size() >= 2) check("periodic_second", rises[1] - rises[0], 32'd12);
        wr(32'h0400_0000, 32'd0);
        wr(32'h0400_000C, 32'd1);

        // One-shot: expiry lands on the edge that completes the next access
        wr(32'h0400_0008, 32'd5);
        wr(32'h0400_0004, 32'd2);
        wr_at(32'h0400_0000, 32'h0000_0001, t_en);
        bus(32'h0400_000C, 4'h0, 32'd0, r, got, at);
        check("oneshot_at", at - t_en, 32'd3);
        check("oneshot_pre", r, 32'd0);
        rd_chk(32'h0400_000C, 32'd1, "oneshot_exp");
        rd_chk(32'h0400_0000, 32'd0, "oneshot_en_clr");
        rd_chk(32'h0400_0004, 32'd0, "oneshot_count");
        check("oneshot_irq", {31'd0, irq}, 32'd0);

        // W1C of STATUS on the expiry edge keeps EXP set
        wr(32'h0400_000C, 32'd1);
        wr(32'h0400_0004, 32'd2);
        wr_at(32'h0400_0000, 32'h0000_0001, t_en);
        bus(32'h0400_000C, 4'hF, 32'd1, r, got, at);
        check("w1c_at", at - t_en, 32'd3);
        rd_chk(32'h0400_000C, 32'd1, "w1c_collision");

        // COUNT write on a tick edge discards the tick
        wr(32'h0400_000C, 32'd1);
        wr(32'h0400_0004, 32'd1000);
        wr_at(32'h0400_0000, 32'h0002_0001, t_en);
        bus(32'h0400_0004, 4'hF, 32'd100, r, got, at);
        check("count_wr_at", at - t_en, 32'd3);
        rd_chk(32'h0400_0004, 32'd100, "count_collision");
        wr(32'h0400_0000, 32'd0);

        // Foreign window is ignored
        wr(32'h0400_0004, 32'h55);
        bus(32'h0300_0004, 4'hF, 32'h0000_DEAD, r, got, at);
        check("window_no_ack", {31'd0, got}, 32'd0);
        rd_chk(32'h0400_0004, 32'h55, "window_count");

        // Reset while counting
        wr(32'h0400_0004, 32'd1000);
        wr(32'h0400_0008, 32'd7);
        wr(32'h0400_0000, 32'h0001_0007);
        repeat (5) @(posedge clk);
        pulse_reset();
        rd_chk(32'h0400_0000, 32'd0, "midrst_ctrl");
        rd_chk(32'h0400_0004, 32'd0, "midrst_count");
        rd_chk(32'h0400_0008, 32'd0, "midrst_reload");
        rd_chk(32'h0400_000C, 32'd0, "midrst_status");
        check("midrst_irq", {31'd0, irq}, 32'd0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
